// File: rtl/ram_block.sv
// ram_block
// ---------
// Single-port, word-addressed RAM for the 8-bit processor datapath.
// Depth is 2**adlines words of datalines bits. Writes are synchronous and
// reads are registered, so read data appears one cycle after the read strobe.
//
// Strobe semantics: read and write are sampled on every rising clk edge.
// There is no backpressure; a strobe seen at an edge always completes there.
// dataout changes only on an edge with read=1 and otherwise holds its value.
// When read and write are both high, the value being written is returned
// (write-through).
//
// Optional feature macro: RAM_ZERO_ON_RESET_EN
//   defined   : all memory words are cleared asynchronously while rst_n=0.
//   undefined : the memory has no reset and stays inferable as block RAM.
//               Unwritten words read X in simulation.
//
// Ports:
//   clk      - clock; all state changes on its rising edge
//   rst_n    - asynchronous active-low reset (clears dataout)
//   address  - word address for both read and write
//   datain   - write data
//   write    - write strobe, active-high
//   read     - read strobe, active-high
//   dataout  - registered read data

module ram_block #(
    parameter int adlines   = 8,
    parameter int datalines = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [adlines-1:0]   address,
    input  logic [datalines-1:0] datain,
    input  logic                 write,
    input  logic                 read,
    output logic [datalines-1:0] dataout
);

    localparam int depth = 2 ** adlines;

    logic [datalines-1:0] mem [depth];

`ifdef RAM_ZERO_ON_RESET_EN
    // Every word is held at zero while reset is asserted; a write that was
    // in flight when reset arrived is discarded along with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else if (write) begin
            mem[address] <= datain;
        end
    end
`else
    // No reset on the array so it maps onto block RAM. Qualifying with rst_n
    // keeps strobes from landing while reset is held.
    always_ff @(posedge clk) begin
        if (write && rst_n) begin
            mem[address] <= datain;
        end
    end
`endif

    // Registered read port. On a simultaneous read/write, forward datain so
    // the caller sees the new word rather than the old array contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataout <= '0;
        end else if (read) begin
            if (write) begin
                dataout <= datain;
            end else begin
                dataout <= mem[address];
            end
        end
    end

endmodule

// File: tb/tb_ram_block.sv
// Testbench for ram_block: directed vectors with hand-computed expectations.
// The driver pushes expected dataout values into exp_q; the monitor pops and
// compares one cycle after each flagged edge, or immediately on an
// asynchronous reset event.

module tb_ram_block;

    localparam int AW = 8;
    localparam int DW = 16;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] datain = '0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [DW-1:0] dataout;

    always #5 clk = ~clk;

    ram_block #(.adlines(AW), .datalines(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .address (address),
        .datain  (datain),
        .write   (write),
        .read    (read),
        .dataout (dataout)
    );

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    string         name_q[$];
    int            checks = 0;
    int            errors = 0;
    logic          issue_chk = 1'b0;
    event          rst_chk;

    task automatic compare_one();
        logic [DW-1:0] e;
        string         n;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: dataout=%h, no expected value queued", dataout);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (dataout !== e) begin
                errors++;
                $display("FAIL %s: dataout=%h expected=%h", n, dataout, e);
            end
        end
    endtask

    // Monitor: edge-based checks one step after the flagged edge.
    always @(posedge clk) begin
        if (issue_chk) begin
            #1;
            compare_one();
        end
    end

    // Monitor: asynchronous reset checks with no clock edge involved.
    always @(rst_chk) begin
        compare_one();
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic wr, input logic rd,
                         input logic chk, input logic [DW-1:0] e, input string n);
        @(negedge clk);
        address   = a;
        datain    = d;
        write     = wr;
        read      = rd;
        issue_chk = chk;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(n);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int n);
        for (int i = 0; i < n; i++) cycle(a, d, 1'b1, 1'b0, 1'b0, '0, "");
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e, input string n);
        cycle(a, 16'h0000, 1'b0, 1'b1, 1'b1, e, n);
    endtask

    task automatic idle();
        cycle(address, datain, 1'b0, 1'b0, 1'b0, '0, "");
    endtask

    // Assert reset between edges with strobes active, check dataout clears
    // without a clock, hold through one edge, then release at a negedge.
    task automatic mid_reset();
        @(negedge clk);
        address   = 8'd65;
        datain    = 16'hBEEF;
        write     = 1'b1;
        read      = 1'b1;
        issue_chk = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(16'h0000);
        name_q.push_back("async_reset_clears_dataout");
        exp_q.push_back(16'h0000);
        name_q.push_back("reset_ignores_strobes");
        -> rst_chk;
        @(negedge clk);
        issue_chk = 1'b0;
        write     = 1'b0;
        read      = 1'b0;
        rst_n     = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Initial reset
        repeat (2) @(negedge clk);
        exp_q.push_back(16'h0000);
        name_q.push_back("reset_dataout");
        -> rst_chk;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef RAM_ZERO_ON_RESET_EN
        do_read(8'd0, 16'd0, "zeroed_addr0");
        do_read(8'd1, 16'd0, "zeroed_addr1");
        do_read(8'd2, 16'd0, "zeroed_addr2");
`endif

        do_write(8'd11, 16'd10, 3);
        do_write(8'd19, 16'd17, 2);
        do_write(8'd65, 16'd1003, 3);

        // Sweep with read held high; dataout tracks address one cycle late.
`ifdef RAM_ZERO_ON_RESET_EN
        do_read(8'd0, 16'd0, "sweep_addr0");
        do_read(8'd1, 16'd0, "sweep_addr1");
        do_read(8'd2, 16'd0, "sweep_addr2");
`endif
        do_read(8'd11, 16'd10, "sweep_addr11");
`ifdef RAM_ZERO_ON_RESET_EN
        do_read(8'd17, 16'd0, "sweep_addr17");
`endif
        do_read(8'd65, 16'd1003, "sweep_addr65");
        do_read(8'd19, 16'd17, "sweep_addr19");

        // Read 65 then drop read and move the address: dataout must hold.
        do_read(8'd65, 16'd1003, "read_addr65_again");
        cycle(8'd11, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd1003, "hold_read_low_1");
        cycle(8'd11, 16'h0000, 1'b0, 1'b0, 1'b1, 16'd1003, "hold_read_low_2");

        // Write-through on simultaneous read and write.
        cycle(8'd40, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h1234, "write_through_40");
        // write=0 with stray datain must leave memory untouched.
        cycle(8'd11, 16'hDEAD, 1'b0, 1'b1, 1'b1, 16'd10, "read11_stray_datain");
        do_read(8'd11, 16'd10, "read11_unchanged");
        do_read(8'd40, 16'h1234, "read40_after_wt");

        // Top of range and bottom word independence.
        do_write(8'd0, 16'h5A5A, 1);
        do_write(8'd255, 16'hFFFF, 2);
        do_read(8'd255, 16'hFFFF, "read_addr255");
        do_read(8'd0, 16'h5A5A, "addr0_unaffected");

        // Asynchronous reset mid-operation.
        mid_reset();
`ifdef RAM_ZERO_ON_RESET_EN
        do_read(8'd11, 16'd0, "addr11_cleared_by_reset");
        do_read(8'd65, 16'd0, "addr65_cleared_by_reset");
`else
        do_read(8'd65, 16'd1003, "addr65_kept_over_reset");
        do_read(8'd11, 16'd10, "addr11_kept_over_reset");
`endif
        idle();
        idle();

        // Every expectation must have been consumed.
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t limit=100000", $time);
        $fatal(1, "timeout");
    end

endmodule
